tlrot_tl_arb: RTL and testbench



---
 rtl/tlrot_tl_arb_if.sv | 38 +++
 rtl/tlrot_tl_arb.sv | 182 ++++++++++++++++++
 tb/tb_tlrot_tl_arb.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlrot_tl_arb_if.sv
// TL-UL link bundle shared by the two host ports and the ROT port of
// tlrot_tl_arb. The master modport is the side that issues A requests and
// consumes D responses; the slave modport is the responding side.
interface tlrot_tl_arb_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_denied;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_denied
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_denied
  );
endinterface

// File: rtl/tlrot_tl_arb.sv
// tlrot_tl_arb: two-host TL-UL arbiter in front of the TLROT_top slave port.
// Host 0 (core MMIO) and host 1 (secure-boot sequencer) are granted round-robin
// with zero added latency; an in-order tag FIFO steers D responses back.
// Optional feature macro TLROT_TL_ARB_ADDR_FILTER_EN: host-1 accesses outside
// [H1_BASE, H1_BASE+H1_SIZE) are answered locally with a denied response.
module tlrot_tl_arb #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] H1_BASE = 32'h0000_0000,
  parameter logic [31:0] H1_SIZE = 32'h0000_1000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tlrot_tl_arb_if.slave  h0_if,
  tlrot_tl_arb_if.slave  h1_if,
  tlrot_tl_arb_if.master rot_if
);

  localparam int            PtrW      = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

`ifdef TLROT_TL_ARB_ADDR_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  typedef struct packed {
    logic       host;
    logic       isLocal;
    logic       isGet;
    logic [1:0] size;
    logic [7:0] source;
  } tag_t;

  tag_t            fifoMem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            prio_q, prio_d;
  logic            err_q, err_d;

  logic            full, empty;
  logic            elig0, elig1, anyElig, grantHost, grantLocal;
  logic            h1Outside;
  logic [32:0]     h1Addr, winLo, winHi;
  logic            push, pop, drop;
  tag_t            pushEntry, head;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign head  = fifoMem_q[rdPtr_q];

  // 33-bit window compare so a window that ends at 2^32 does not wrap.
  assign h1Addr    = {1'b0, h1_if.a_address};
  assign winLo     = {1'b0, H1_BASE};
  assign winHi     = {1'b0, H1_BASE} + {1'b0, H1_SIZE};
  assign h1Outside = (h1Addr < winLo) || (h1Addr >= winHi);

  // Arbitration and A forwarding: grant, steer winner onto ROT, compute push.
  always_comb begin
    elig0      = h0_if.a_valid && !full && !rst_i;
    elig1      = h1_if.a_valid && !full && !rst_i;
    anyElig    = elig0 || elig1;
    grantHost  = (elig0 && elig1) ? prio_q : elig1;
    grantLocal = FilterEn && anyElig && grantHost && h1Outside;

    rot_if.a_valid   = anyElig && !grantLocal;
    rot_if.a_opcode  = grantHost ? h1_if.a_opcode  : h0_if.a_opcode;
    rot_if.a_param   = grantHost ? h1_if.a_param   : h0_if.a_param;
    rot_if.a_size    = grantHost ? h1_if.a_size    : h0_if.a_size;
    rot_if.a_source  = grantHost ? h1_if.a_source  : h0_if.a_source;
    rot_if.a_address = grantHost ? h1_if.a_address : h0_if.a_address;
    rot_if.a_mask    = grantHost ? h1_if.a_mask    : h0_if.a_mask;
    rot_if.a_data    = grantHost ? h1_if.a_data    : h0_if.a_data;

    h0_if.a_ready = anyElig && !grantHost && rot_if.a_ready;
    h1_if.a_ready = anyElig && grantHost && (grantLocal || rot_if.a_ready);
    push          = anyElig && (grantLocal || rot_if.a_ready);

    pushEntry.host    = grantHost;
    pushEntry.isLocal = grantLocal;
    pushEntry.isGet   = (rot_if.a_opcode == 3'd4);
    pushEntry.size    = rot_if.a_size;
    pushEntry.source  = rot_if.a_source;
  end

  // Response routing: the FIFO head decides which host sees the D beat.
  always_comb begin
    h0_if.d_valid  = 1'b0;
    h0_if.d_opcode = rot_if.d_opcode;
    h0_if.d_param  = rot_if.d_param;
    h0_if.d_size   = rot_if.d_size;
    h0_if.d_source = rot_if.d_source;
    h0_if.d_sink   = rot_if.d_sink;
    h0_if.d_data   = rot_if.d_data;
    h0_if.d_denied = rot_if.d_denied;
    h1_if.d_valid  = 1'b0;
    h1_if.d_opcode = rot_if.d_opcode;
    h1_if.d_param  = rot_if.d_param;
    h1_if.d_size   = rot_if.d_size;
    h1_if.d_source = rot_if.d_source;
    h1_if.d_sink   = rot_if.d_sink;
    h1_if.d_data   = rot_if.d_data;
    h1_if.d_denied = rot_if.d_denied;
    rot_if.d_ready = 1'b0;
    pop            = 1'b0;
    drop           = 1'b0;
    if (rst_i) begin
      pop = 1'b0;
    end else if (empty) begin
      rot_if.d_ready = rot_if.d_valid;
      drop           = rot_if.d_valid;
    end else if (head.isLocal) begin
      h1_if.d_valid  = 1'b1;
      h1_if.d_opcode = head.isGet ? 3'd1 : 3'd0;
      h1_if.d_param  = 3'd0;
      h1_if.d_size   = head.size;
      h1_if.d_source = head.source;
      h1_if.d_sink   = 1'b0;
      h1_if.d_data   = 32'h0;
      h1_if.d_denied = 1'b1;
      pop            = h1_if.d_ready;
    end else if (head.host) begin
      h1_if.d_valid  = rot_if.d_valid;
      rot_if.d_ready = h1_if.d_ready;
      pop            = rot_if.d_valid && h1_if.d_ready;
    end else begin
      h0_if.d_valid  = rot_if.d_valid;
      rot_if.d_ready = h0_if.d_ready;
      pop            = rot_if.d_valid && h0_if.d_ready;
    end
  end

  // Next-state for pointers, occupancy, round-robin priority and error flag.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    prio_d  = prio_q;
    err_d   = err_q || drop;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
      prio_d  = ~grantHost;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset drops every outstanding tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end

  // Tag storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= pushEntry;
    end
  end

  // Stray-response flag stays set until reset; the FIFO never overflows.
  errSticky: assert property (@(posedge clk_i) disable iff (rst_i) err_q |=> err_q);
  noOverflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: tb/tb_tlrot_tl_arb.sv
// Self-checking bench for tlrot_tl_arb. Expected D responses are queued on
// acceptance and compared when a host sees its D beat.
module tb_tlrot_tl_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tlrot_tl_arb_if h0Bus ();
  tlrot_tl_arb_if h1Bus ();
  tlrot_tl_arb_if rotBus ();

  tlrot_tl_arb #(.DEPTH(4), .H1_BASE(32'h0000_0000), .H1_SIZE(32'h0000_1000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .h0_if (h0Bus),
    .h1_if (h1Bus),
    .rot_if(rotBus)
  );

  typedef struct {
    bit          host;
    logic [7:0]  source;
    logic [31:0] data;
  } resp_t;

  resp_t      respQ[$];
  logic [7:0] rotQ[$];
  bit         grantQ[$];

  // Park every bench-driven input in an idle state.
  task automatic idleAll();
    h0Bus.a_valid = 0; h0Bus.a_opcode = 0; h0Bus.a_param = 0; h0Bus.a_size = 2;
    h0Bus.a_source = 0; h0Bus.a_address = 0; h0Bus.a_mask = 4'hF; h0Bus.a_data = 0;
    h0Bus.d_ready = 1;
    h1Bus.a_valid = 0; h1Bus.a_opcode = 0; h1Bus.a_param = 0; h1Bus.a_size = 2;
    h1Bus.a_source = 0; h1Bus.a_address = 0; h1Bus.a_mask = 4'hF; h1Bus.a_data = 0;
    h1Bus.d_ready = 1;
    rotBus.a_ready = 1;
    rotBus.d_valid = 0; rotBus.d_opcode = 0; rotBus.d_param = 0; rotBus.d_size = 2;
    rotBus.d_source = 0; rotBus.d_sink = 0; rotBus.d_data = 0; rotBus.d_denied = 0;
  endtask

  // Raise a request on one host.
  task automatic applyStimulus(input bit host, input logic [2:0] opcode,
                               input logic [31:0] addr, input logic [7:0] source);
    if (host) begin
      h1Bus.a_valid = 1; h1Bus.a_opcode = opcode; h1Bus.a_address = addr; h1Bus.a_source = source;
    end else begin
      h0Bus.a_valid = 1; h0Bus.a_opcode = opcode; h0Bus.a_address = addr; h0Bus.a_source = source;
    end
  endtask

  // Drive the ROT D channel with an AccessAckData whose data encodes the source.
  task automatic rotRespond(input logic [7:0] source, input logic [2:0] opcode);
    rotBus.d_valid = 1; rotBus.d_opcode = opcode; rotBus.d_source = source;
    rotBus.d_data = 32'hD000_0000 | {24'h0, source}; rotBus.d_denied = 0;
  endtask

  // Synchronous reset for two edges; leaves us at posedge+1 with reset low.
  task automatic doReset();
    rst = 1;
    idleAll();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    respQ.delete(); rotQ.delete(); grantQ.delete();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    string nm [6];
    nm = '{"h0_a_ready", "h1_a_ready", "rot_a_valid", "h0_d_valid", "h1_d_valid", "rot_d_ready"};
    rst = 1;
    idleAll();
    h0Bus.a_valid = 1; h1Bus.a_valid = 1; rotBus.d_valid = 1;
    @(posedge clk);
    @(negedge clk);
    obs = {rotBus.d_ready, h1Bus.d_valid, h0Bus.d_valid, rotBus.a_valid, h1Bus.a_ready, h0Bus.a_ready};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_%s: got %b want 0", nm[i], obs[i]);
      end
    end
    @(posedge clk);
    #1 rst = 0;
    idleAll();
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1'b0 || rotBus.d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: rot_a_valid=%b rot_d_ready=%b want 0/0", rotBus.a_valid, rotBus.d_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_get();
    resp_t exp;
    applyStimulus(0, 3'd4, 32'h100, 8'h12);
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || rotBus.a_address !== 32'h100 || rotBus.a_source !== 8'h12 ||
        rotBus.a_opcode !== 3'd4 || h0Bus.a_ready !== 1) begin
      errors++;
      $display("[TB] FAIL single_fwd: valid=%b addr=%h src=%h op=%0d rdy=%b want 1/100/12/4/1",
               rotBus.a_valid, rotBus.a_address, rotBus.a_source, rotBus.a_opcode, h0Bus.a_ready);
    end
    respQ.push_back('{host: 0, source: 8'h12, data: 32'hDEAD_BEEF});
    @(posedge clk); #1;
    h0Bus.a_valid = 0;
    rotBus.d_valid = 1; rotBus.d_opcode = 3'd1; rotBus.d_source = 8'h12;
    rotBus.d_data = 32'hDEAD_BEEF; rotBus.d_denied = 0;
    @(negedge clk);
    exp = respQ.pop_front();
    checks++;
    if (h0Bus.d_valid !== 1 || h0Bus.d_data !== exp.data || h0Bus.d_source !== exp.source ||
        h0Bus.d_opcode !== 3'd1 || h0Bus.d_denied !== 0) begin
      errors++;
      $display("[TB] FAIL single_resp: valid=%b data=%h src=%h op=%0d den=%b want 1/%h/%h/1/0",
               h0Bus.d_valid, h0Bus.d_data, h0Bus.d_source, h0Bus.d_opcode, h0Bus.d_denied, exp.data, exp.source);
    end
    checks++;
    if (h1Bus.d_valid !== 0 || rotBus.d_ready !== 1) begin
      errors++;
      $display("[TB] FAIL single_steer: h1_d_valid=%b rot_d_ready=%b want 0/1", h1Bus.d_valid, rotBus.d_ready);
    end
    @(posedge clk); #1;
    rotBus.d_valid = 0;
    @(negedge clk);
    checks++;
    if (h0Bus.d_valid !== 0) begin
      errors++; $display("[TB] FAIL single_done: h0_d_valid=%b want 0", h0Bus.d_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [7:0] src0, src1, expSrc, src;
    bit         expHost;
    resp_t      exp;
    doReset();
    src0 = 8'hA0; src1 = 8'hB0;
    grantQ.push_back(0); grantQ.push_back(1); grantQ.push_back(0); grantQ.push_back(1);
    applyStimulus(0, 3'd4, 32'h10, src0);
    applyStimulus(1, 3'd4, 32'h20, src1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expHost = grantQ.pop_front();
      expSrc  = expHost ? src1 : src0;
      checks++;
      if (rotBus.a_valid !== 1 || rotBus.a_source !== expSrc ||
          h0Bus.a_ready !== !expHost || h1Bus.a_ready !== expHost) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: src=%h rdy0=%b rdy1=%b want src=%h host=%0d",
                 i, rotBus.a_source, h0Bus.a_ready, h1Bus.a_ready, expSrc, expHost);
      end
      respQ.push_back('{host: expHost, source: expSrc, data: 32'hD000_0000 | {24'h0, expSrc}});
      rotQ.push_back(expSrc);
      @(posedge clk); #1;
      if (expHost) begin src1++; h1Bus.a_source = src1; end
      else begin src0++; h0Bus.a_source = src0; end
    end
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 0 || h0Bus.a_ready !== 0 || h1Bus.a_ready !== 0) begin
      errors++;
      $display("[TB] FAIL contention_full: rot_a_valid=%b rdy0=%b rdy1=%b want 0/0/0",
               rotBus.a_valid, h0Bus.a_ready, h1Bus.a_ready);
    end
    @(posedge clk); #1;
    h0Bus.a_valid = 0; h1Bus.a_valid = 0;
    while (rotQ.size() > 0) begin
      src = rotQ.pop_front();
      rotRespond(src, 3'd1);
      @(negedge clk);
      exp = respQ.pop_front();
      checks++;
      if ((exp.host ? h1Bus.d_valid : h0Bus.d_valid) !== 1 || (exp.host ? h0Bus.d_valid : h1Bus.d_valid) !== 0 ||
          (exp.host ? h1Bus.d_source : h0Bus.d_source) !== exp.source ||
          (exp.host ? h1Bus.d_data : h0Bus.d_data) !== exp.data) begin
        errors++;
        $display("[TB] FAIL contention_resp: v0=%b v1=%b want host=%0d src=%h data=%h",
                 h0Bus.d_valid, h1Bus.d_valid, exp.host, exp.source, exp.data);
      end
      @(posedge clk); #1;
    end
    rotBus.d_valid = 0;
  endtask

  task automatic test_full_fifo();
    int         accepted;
    logic [7:0] src;
    resp_t      exp;
    doReset();
    accepted = 0;
    applyStimulus(0, 3'd4, 32'h200, 8'h40);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (accepted < 4) begin
        if (rotBus.a_valid !== 1 || h0Bus.a_ready !== 1 || rotBus.a_source !== 8'h40 + 8'(accepted)) begin
          errors++;
          $display("[TB] FAIL full_fwd%0d: valid=%b rdy=%b src=%h want 1/1/%h",
                   cyc, rotBus.a_valid, h0Bus.a_ready, rotBus.a_source, 8'h40 + 8'(accepted));
        end
        respQ.push_back('{host: 0, source: 8'h40 + 8'(accepted), data: 32'hD000_0040 + accepted});
        rotQ.push_back(8'h40 + 8'(accepted));
      end else if (rotBus.a_valid !== 0 || h0Bus.a_ready !== 0) begin
        errors++;
        $display("[TB] FAIL full_block%0d: valid=%b rdy=%b want 0/0", cyc, rotBus.a_valid, h0Bus.a_ready);
      end
      @(posedge clk); #1;
      if (accepted < 4) begin accepted++; h0Bus.a_source = 8'h40 + 8'(accepted); end
    end
    src = rotQ.pop_front();
    rotRespond(src, 3'd1);
    @(negedge clk);
    exp = respQ.pop_front();
    checks++;
    if (h0Bus.d_valid !== 1 || h0Bus.d_source !== exp.source || h0Bus.a_ready !== 0 || rotBus.a_valid !== 0) begin
      errors++;
      $display("[TB] FAIL full_pop_cycle: d_valid=%b src=%h a_ready=%b rot_a_valid=%b want 1/%h/0/0",
               h0Bus.d_valid, h0Bus.d_source, h0Bus.a_ready, rotBus.a_valid, exp.source);
    end
    @(posedge clk); #1;
    rotBus.d_valid = 0;
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || h0Bus.a_ready !== 1 || rotBus.a_source !== 8'h44) begin
      errors++;
      $display("[TB] FAIL full_fifth: valid=%b rdy=%b src=%h want 1/1/44", rotBus.a_valid, h0Bus.a_ready, rotBus.a_source);
    end
    respQ.push_back('{host: 0, source: 8'h44, data: 32'hD000_0044});
    rotQ.push_back(8'h44);
    @(posedge clk); #1;
    h0Bus.a_valid = 0;
    while (rotQ.size() > 0) begin
      src = rotQ.pop_front();
      rotRespond(src, 3'd1);
      @(negedge clk);
      exp = respQ.pop_front();
      checks++;
      if (h0Bus.d_valid !== 1 || h1Bus.d_valid !== 0 || h0Bus.d_source !== exp.source || h0Bus.d_data !== exp.data) begin
        errors++;
        $display("[TB] FAIL full_drain: v0=%b v1=%b src=%h data=%h want 1/0/%h/%h",
                 h0Bus.d_valid, h1Bus.d_valid, h0Bus.d_source, h0Bus.d_data, exp.source, exp.data);
      end
      @(posedge clk); #1;
    end
    rotBus.d_valid = 0;
  endtask

  task automatic test_mid_reset();
    logic [5:0] obs;
    logic [7:0] src;
    resp_t      exp;
    doReset();
    applyStimulus(0, 3'd4, 32'h300, 8'h60);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (h0Bus.a_ready !== 1) begin
        errors++; $display("[TB] FAIL midrst_fill%0d: a_ready=%b want 1", i, h0Bus.a_ready);
      end
      @(posedge clk); #1;
      h0Bus.a_source = 8'h61 + 8'(i);
    end
    rst = 1;
    applyStimulus(1, 3'd4, 32'h380, 8'h70);
    rotRespond(8'h60, 3'd1);
    @(negedge clk);
    obs = {rotBus.d_ready, h1Bus.d_valid, h0Bus.d_valid, rotBus.a_valid, h1Bus.a_ready, h0Bus.a_ready};
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got %b want 000000", obs);
    end
    @(posedge clk); #1;
    rst = 0;
    rotBus.d_valid = 0;
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || rotBus.a_source !== 8'h63 || h0Bus.a_ready !== 1 || h1Bus.a_ready !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_prio: src=%h rdy0=%b rdy1=%b want 63/1/0", rotBus.a_source, h0Bus.a_ready, h1Bus.a_ready);
    end
    respQ.push_back('{host: 0, source: 8'h63, data: 32'hD000_0063});
    rotQ.push_back(8'h63);
    @(posedge clk); #1;
    h0Bus.a_valid = 0;
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || rotBus.a_source !== 8'h70 || h1Bus.a_ready !== 1) begin
      errors++;
      $display("[TB] FAIL midrst_h1: valid=%b src=%h rdy1=%b want 1/70/1", rotBus.a_valid, rotBus.a_source, h1Bus.a_ready);
    end
    respQ.push_back('{host: 1, source: 8'h70, data: 32'hD000_0070});
    rotQ.push_back(8'h70);
    @(posedge clk); #1;
    h1Bus.a_valid = 0;
    while (rotQ.size() > 0) begin
      src = rotQ.pop_front();
      rotRespond(src, 3'd1);
      @(negedge clk);
      exp = respQ.pop_front();
      checks++;
      if ((exp.host ? h1Bus.d_valid : h0Bus.d_valid) !== 1 || (exp.host ? h0Bus.d_valid : h1Bus.d_valid) !== 0 ||
          (exp.host ? h1Bus.d_source : h0Bus.d_source) !== exp.source) begin
        errors++;
        $display("[TB] FAIL midrst_resp: v0=%b v1=%b want host=%0d src=%h", h0Bus.d_valid, h1Bus.d_valid, exp.host, exp.source);
      end
      @(posedge clk); #1;
    end
    rotBus.d_valid = 0;
  endtask

`ifdef TLROT_TL_ARB_ADDR_FILTER_EN
  task automatic test_filter_get();
    resp_t exp;
    doReset();
    applyStimulus(1, 3'd4, 32'h2000, 8'h33);
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 0 || h1Bus.a_ready !== 1) begin
      errors++; $display("[TB] FAIL filter_accept: rot_a_valid=%b rdy1=%b want 0/1", rotBus.a_valid, h1Bus.a_ready);
    end
    respQ.push_back('{host: 1, source: 8'h33, data: 32'h0});
    @(posedge clk); #1;
    h1Bus.a_valid = 0;
    @(negedge clk);
    exp = respQ.pop_front();
    checks++;
    if (h1Bus.d_valid !== 1 || h1Bus.d_opcode !== 3'd1 || h1Bus.d_denied !== 1 || h1Bus.d_data !== exp.data ||
        h1Bus.d_source !== exp.source || h1Bus.d_size !== 2'd2 || rotBus.d_ready !== 0 || h0Bus.d_valid !== 0) begin
      errors++;
      $display("[TB] FAIL filter_local: v=%b op=%0d den=%b data=%h src=%h size=%0d rot_rdy=%b want 1/1/1/0/33/2/0",
               h1Bus.d_valid, h1Bus.d_opcode, h1Bus.d_denied, h1Bus.d_data, h1Bus.d_source, h1Bus.d_size, rotBus.d_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (h1Bus.d_valid !== 0) begin
      errors++; $display("[TB] FAIL filter_popped: h1_d_valid=%b want 0", h1Bus.d_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_filter_order();
    doReset();
    applyStimulus(1, 3'd0, 32'hFFC, 8'h01);
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || rotBus.a_address !== 32'hFFC) begin
      errors++; $display("[TB] FAIL order_inwin: valid=%b addr=%h want 1/ffc", rotBus.a_valid, rotBus.a_address);
    end
    @(posedge clk); #1;
    applyStimulus(1, 3'd4, 32'h1000, 8'h02);
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 0 || h1Bus.a_ready !== 1) begin
      errors++; $display("[TB] FAIL order_edge: rot_a_valid=%b rdy1=%b want 0/1", rotBus.a_valid, h1Bus.a_ready);
    end
    @(posedge clk); #1;
    h1Bus.a_valid = 0;
    @(negedge clk);
    checks++;
    if (h1Bus.d_valid !== 0) begin
      errors++; $display("[TB] FAIL order_wait: h1_d_valid=%b want 0", h1Bus.d_valid);
    end
    @(posedge clk); #1;
    rotRespond(8'h01, 3'd0);
    @(negedge clk);
    checks++;
    if (h1Bus.d_valid !== 1 || h1Bus.d_opcode !== 3'd0 || h1Bus.d_denied !== 0 || h1Bus.d_source !== 8'h01) begin
      errors++;
      $display("[TB] FAIL order_first: v=%b op=%0d den=%b src=%h want 1/0/0/01",
               h1Bus.d_valid, h1Bus.d_opcode, h1Bus.d_denied, h1Bus.d_source);
    end
    @(posedge clk); #1;
    rotBus.d_valid = 0;
    @(negedge clk);
    checks++;
    if (h1Bus.d_valid !== 1 || h1Bus.d_opcode !== 3'd1 || h1Bus.d_denied !== 1 || h1Bus.d_source !== 8'h02) begin
      errors++;
      $display("[TB] FAIL order_second: v=%b op=%0d den=%b src=%h want 1/1/1/02",
               h1Bus.d_valid, h1Bus.d_opcode, h1Bus.d_denied, h1Bus.d_source);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_unfiltered();
    resp_t exp;
    doReset();
    applyStimulus(1, 3'd4, 32'h2000, 8'h33);
    @(negedge clk);
    checks++;
    if (rotBus.a_valid !== 1 || rotBus.a_address !== 32'h2000 || h1Bus.a_ready !== 1) begin
      errors++;
      $display("[TB] FAIL unfiltered_fwd: valid=%b addr=%h rdy1=%b want 1/2000/1", rotBus.a_valid, rotBus.a_address, h1Bus.a_ready);
    end
    respQ.push_back('{host: 1, source: 8'h33, data: 32'hD000_0033});
    @(posedge clk); #1;
    h1Bus.a_valid = 0;
    rotRespond(8'h33, 3'd1);
    @(negedge clk);
    exp = respQ.pop_front();
    checks++;
    if (h1Bus.d_valid !== 1 || h1Bus.d_denied !== 0 || h1Bus.d_data !== exp.data || h1Bus.d_source !== exp.source) begin
      errors++;
      $display("[TB] FAIL unfiltered_resp: v=%b den=%b data=%h src=%h want 1/0/%h/%h",
               h1Bus.d_valid, h1Bus.d_denied, h1Bus.d_data, h1Bus.d_source, exp.data, exp.source);
    end
    @(posedge clk); #1;
    rotBus.d_valid = 0;
  endtask
`endif

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    idleAll();
    test_reset();
    test_single_get();
    test_contention();
    test_full_fifo();
    test_mid_reset();
`ifdef TLROT_TL_ARB_ADDR_FILTER_EN
    test_filter_get();
    test_filter_order();
`else
    test_unfiltered();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
